seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have one parameter: DIV, default 4, clock cycles each digit is lit per scan slot (legal range 2..65535).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  scan enable; 0 blanks the display and holds the scan in IDLE.
REQ-005 load  input  1  request to take a new 4-digit value; accepted only when ready=1.
REQ-006 value_in  input  16  four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-007 blank_lz  input  1  leading-zero blanking enable.
REQ-008 bcd_out  output  4  BCD digit currently presented to the external 7-segment decoder.
REQ-009 dig_en  output  4  one-hot active-high digit enable; bit k lights digit k.
REQ-010 ready  output  1  1 when no committed-pending value is held.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full 4-digit scan.
REQ-012 err  output  1  1 while the active value contains a non-BCD digit (>9).

Function
REQ-013 The block SHALL hold a shadow register, a pending flag, an active register, a 2-bit digit index idx, and a prescaler pre counting 0..DIV-1.
REQ-014 The FSM SHALL have states IDLE, ON and GAP.
REQ-015 IDLE: dig_en=0, idx=0, pre=0; en=1 -> ON next cycle.
REQ-016 ON: dig_en=one-hot(idx) unless blanked; pre increments each cycle; when pre=DIV-1 -> GAP and pre=0.
REQ-017 GAP: dig_en=0 for exactly one cycle (anti-ghosting); then idx=idx+1 mod 4 and -> ON.
REQ-018 GAP with idx=3 SHALL be the frame end: frame_done=1 that cycle, idx wraps to 0.
REQ-019 One frame SHALL last exactly 4*(DIV+1) cycles; dig_en SHALL never have more than one bit set.
REQ-020 en=0 in ON or GAP SHALL force IDLE on the next edge with dig_en=0 from that edge; no frame_done is issued for the aborted frame.
REQ-021 bcd_out SHALL equal active[4*idx+3:4*idx] in every state, including IDLE (digit 0).
REQ-022 load=1 with ready=1 SHALL capture value_in into shadow, set pending and clear ready on the next edge.
REQ-023 load=1 with ready=0 SHALL be ignored; shadow is unchanged.
REQ-024 Commit (active<=shadow, pending cleared, ready=1) SHALL occur on the frame-end edge, or on the first edge in which the FSM is in IDLE with pending=1.
REQ-025 A load accepted in the frame-end cycle itself SHALL be committed at the following frame end, never mid-frame; the active value SHALL never change outside a frame end or IDLE.
REQ-026 Leading-zero blanking: with blank_lz=1, digit k (k=1..3) SHALL be blanked (dig_en bit k=0 during its ON slot) when all active digits k..3 equal 0. Digit 0 SHALL never be blanked by this rule.
REQ-027 Slot timing SHALL be unchanged by blanking.
REQ-028 Any active digit >9 SHALL be blanked in its slot; err SHALL equal OR over digits of (digit>9), updated at each commit.
REQ-029 blank_lz SHALL be sampled combinationally; a change takes effect on the next ON slot.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, idx=0, pre=0, shadow=0, active=0, pending=0. Outputs SHALL be bcd_out=0, dig_en=0, ready=1, frame_done=0, err=0.
REQ-031 Reset mid-frame SHALL discard any pending value; after release, scanning SHALL start with digit 0 one cycle after en is seen high.

Verification
REQ-032 DIV=4, en=1, value 16'h1234 loaded in IDLE -> active=1234 next cycle. dig_en sequence: 0001 for 4 cycles, 0000 for 1 cycle, 0010 for 4, 0000 for 1, 0100 for 4, 0000 for 1, 1000 for 4, 0000 for 1. frame_done pulses on cycle 20; bcd_out=4,3,2,1 in the respective slots.
REQ-033 Mid-frame load of 16'h5678 -> ready=0 next cycle; active stays 1234 until frame end, then 5678 and ready=1. A second load during pending is ignored.
REQ-034 blank_lz=1 with value 16'h0040 -> digits 3 and 2 are dark, digits 1 and 0 are lit. With value 16'h0000 -> only digit 0 is lit, showing 0. With blank_lz=0 all four digits are lit.
REQ-035 Value 16'h12A4 -> err=1 after commit; digit 1 is dark; the other digits scan normally. Loading 16'h1234 clears err at the next frame end.
REQ-036 en dropped during the digit-2 slot -> dig_en=0 on the next edge and no frame_done. rst_n pulsed low during pending -> all outputs at reset values asynchronously, ready=1, active=0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Purpose: time-multiplexed 4-digit BCD scan controller with shadow/active value
//          registers, leading-zero blanking and non-BCD digit suppression.
// Latency: accepted load -> active at next frame end (or next cycle when IDLE);
//          frame = 4*(DIV+1) cycles.
// Backpressure: ready=0 while a value is pending; loads seen with ready=0 are dropped.
// Ports: clk/rst_n (async active-low), en (scan enable), load/value_in/ready (value
//        handshake), blank_lz (leading-zero blanking), bcd_out/dig_en (display drive),
//        frame_done (end-of-frame pulse), err (active value holds a digit > 9).
module seven_seg_scan_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd_out,
  output logic [3:0]  dig_en,
  output logic        ready,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] PRE_MAX = 16'(DIV - 1);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [15:0] r_pre;
  logic [15:0] r_shadow;
  logic [15:0] r_active;
  logic        r_pending;
  logic [3:0]  r_dig_en;
  logic        r_frame_done;
  logic        r_err;

  logic        w_frame_end;
  logic        w_commit;
  logic        w_accept;
  logic [15:0] w_act_nxt;
  logic [1:0]  w_idx_on;
  logic [3:0]  w_on_mask;

  // Digit k is shown unless it is non-BCD or it is a leading zero (k>0 and
  // every digit from k upward is zero).
  function automatic logic digit_lit(input logic [15:0] v, input logic [1:0] k,
                                     input logic blz);
    logic [3:0] d;
    logic       lz;
    d = v[{k, 2'b00} +: 4];
    case (k)
      2'd0:    lz = 1'b0;
      2'd1:    lz = (v[15:4] == 12'd0);
      2'd2:    lz = (v[15:8] == 8'd0);
      default: lz = (v[15:12] == 4'd0);
    endcase
    return (d <= 4'd9) && !(blz && lz);
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
  endfunction

  assign w_frame_end = (r_state == S_GAP) && (r_idx == 2'd3);
  assign w_commit    = r_pending && (w_frame_end || (r_state == S_IDLE));
  assign w_accept    = load && !r_pending;
  // Value that will be active after this edge; the slot being entered must be
  // judged against it so a commit at frame end blanks digit 0 correctly.
  assign w_act_nxt   = w_commit ? r_shadow : r_active;
  // Index of the slot entered on this edge (only meaningful when entering ON).
  assign w_idx_on    = (r_state == S_GAP) ? (r_idx + 2'd1) : 2'd0;
  // blank_lz is sampled only on slot entry, so a change never cuts a slot short.
  assign w_on_mask   = digit_lit(w_act_nxt, w_idx_on, blank_lz) ?
                       (4'b0001 << w_idx_on) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_pre        <= 16'd0;
      r_shadow     <= 16'd0;
      r_active     <= 16'd0;
      r_pending    <= 1'b0;
      r_dig_en     <= 4'b0000;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Accept and commit are mutually exclusive: one needs pending clear,
      // the other needs it set.
      if (w_accept) begin
        r_shadow  <= value_in;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
        r_err     <= has_bad(r_shadow);
      end

      r_frame_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_idx    <= 2'd0;
          r_pre    <= 16'd0;
          r_dig_en <= 4'b0000;
          if (en) begin
            r_state  <= S_ON;
            r_dig_en <= w_on_mask;
          end
        end
        S_ON: begin
          if (!en) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_pre    <= 16'd0;
            r_dig_en <= 4'b0000;
          end else if (r_pre == PRE_MAX) begin
            r_state      <= S_GAP;
            r_pre        <= 16'd0;
            r_dig_en     <= 4'b0000;
            // The GAP after digit 3 is the frame-end cycle.
            r_frame_done <= (r_idx == 2'd3);
          end else begin
            r_pre <= r_pre + 16'd1;
          end
        end
        S_GAP: begin
          if (!en) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_pre    <= 16'd0;
            r_dig_en <= 4'b0000;
          end else begin
            r_state  <= S_ON;
            r_idx    <= w_idx_on;
            r_dig_en <= w_on_mask;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_idx    <= 2'd0;
          r_pre    <= 16'd0;
          r_dig_en <= 4'b0000;
        end
      endcase
    end
  end

  assign bcd_out    = r_active[{r_idx, 2'b00} +: 4];
  assign dig_en     = r_dig_en;
  assign ready      = !r_pending;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: vector table of display values,
// hand-written multi-cycle sequences, and randomized traffic against a
// frame-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int SLOT  = DIV + 1;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value_in;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_en;
  logic        ready;
  logic        frame_done;
  logic        err;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value_in   (value_in),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .dig_en     (dig_en),
    .ready      (ready),
    .frame_done (frame_done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The display is described by its position m_t within a scanning frame:
  // slot = m_t / (DIV+1), the last cycle of each slot is the dark gap.
  bit          m_scan;
  int          m_t;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  bit          m_pend;
  bit          m_err;
  bit          m_blz;

  function automatic logic [3:0] dig(input logic [15:0] v, input int k);
    logic [15:0] s;
    s = v >> (4 * k);
    return s[3:0];
  endfunction

  function automatic bit any_bad(input logic [15:0] v);
    for (int k = 0; k < 4; k++) if (dig(v, k) > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit visible(input logic [15:0] v, input int k, input bit blz);
    if (dig(v, k) > 4'd9) return 1'b0;
    if (blz && k > 0 && (v >> (4 * k)) == 16'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_t = 0; m_shadow = 16'd0; m_active = 16'd0;
    m_pend = 0; m_err = 0; m_blz = 0;
  endtask

  task automatic model_edge();
    bit fe, cm;
    fe = m_scan && (m_t == FRAME - 1);
    cm = m_pend && (fe || !m_scan);
    if (load && !m_pend) begin
      m_shadow = value_in;
      m_pend   = 1;
    end else if (cm) begin
      m_active = m_shadow;
      m_pend   = 0;
      m_err    = any_bad(m_shadow);
    end
    if (!en) begin
      m_scan = 0; m_t = 0;
    end else if (!m_scan) begin
      m_scan = 1; m_t = 0;
    end else begin
      m_t = (m_t + 1) % FRAME;
    end
    if (m_scan && (m_t % SLOT) == 0) m_blz = blank_lz;
  endtask

  task automatic model_check();
    int slot, ph;
    logic [3:0] exp_dig;
    slot = m_t / SLOT;
    ph   = m_t % SLOT;
    exp_dig = (m_scan && ph < DIV && visible(m_active, slot, m_blz)) ? 4'(1 << slot) : 4'd0;
    chk("m_dig_en", 32'(dig_en), 32'(exp_dig));
    chk("m_bcd_out", 32'(bcd_out), 32'(dig(m_active, slot)));
    chk("m_ready", 32'(ready), 32'(!m_pend));
    chk("m_frame_done", 32'(frame_done), 32'(m_scan && m_t == FRAME - 1));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_onehot", 32'($countones(dig_en) <= 1), 32'h1);
  endtask

  // One clock: drive at negedge, model advances at posedge, compare at next negedge.
  task automatic step(input logic e, input logic l, input logic [15:0] v, input logic b);
    en = e; load = l; value_in = v; blank_lz = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_bcd"}, 32'(bcd_out), 32'h0);
    chk({p, "_dig_en"}, 32'(dig_en), 32'h0);
    chk({p, "_ready"}, 32'(ready), 32'h1);
    chk({p, "_frame_done"}, 32'(frame_done), 32'h0);
    chk({p, "_err"}, 32'(err), 32'h0);
  endtask

  // Asserts reset between clock edges so the outputs are seen to clear
  // without any clock edge.
  task automatic do_reset(input string p);
    #2 rst_n = 1'b0;
    #1 chk_reset(p);
    model_reset();
    en = 1'b0; load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scan_to_fd(input string p);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      seen = (frame_done === 1'b1);
    end
    chk({p, "_fd_reached"}, 32'(seen), 32'h1);
  endtask

  typedef struct {
    logic [15:0] val;
    logic        blz;
    logic [3:0]  lit;
    logic        err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  lit;
    int          litcnt, fd_cnt, fd_cyc;
    logic [15:0] seen_bcd;
    bit          fd_any;
    logic        cur_b;
    logic [15:0] rv;

    tbl[0] = '{16'h1234, 1'b0, 4'b1111, 1'b0};
    tbl[1] = '{16'h0040, 1'b1, 4'b0011, 1'b0};
    tbl[2] = '{16'h0000, 1'b1, 4'b0001, 1'b0};
    tbl[3] = '{16'h0000, 1'b0, 4'b1111, 1'b0};
    tbl[4] = '{16'h12A4, 1'b0, 4'b1101, 1'b1};
    tbl[5] = '{16'h0900, 1'b1, 4'b0111, 1'b0};
    tbl[6] = '{16'hF000, 1'b1, 4'b0111, 1'b1};
    tbl[7] = '{16'h1234, 1'b1, 4'b1111, 1'b0};
    tbl[8] = '{16'h0005, 1'b1, 4'b0001, 1'b0};

    rst_n = 1'b0; en = 1'b0; load = 1'b0; value_in = 16'h0; blank_lz = 1'b0;
    #1 chk_reset("init");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // ---------- table: load in IDLE, commit, scan one full frame ----------
    for (int r = 0; r < 9; r++) begin
      step(1'b0, 1'b1, tbl[r].val, tbl[r].blz);
      chk("tbl_ready_after_load", 32'(ready), 32'h0);
      step(1'b0, 1'b0, 16'h0, tbl[r].blz);
      chk("tbl_ready_after_commit", 32'(ready), 32'h1);
      chk("tbl_err", 32'(err), 32'(tbl[r].err));
      lit = 4'd0; litcnt = 0; fd_cnt = 0; fd_cyc = 0; seen_bcd = 16'h0;
      for (int c = 1; c <= FRAME; c++) begin
        step(1'b1, 1'b0, 16'h0, tbl[r].blz);
        lit    = lit | dig_en;
        litcnt = litcnt + $countones(dig_en);
        if (frame_done) begin fd_cnt++; fd_cyc = c; end
        if ((c - 1) % SLOT == 0) seen_bcd[4 * ((c - 1) / SLOT) +: 4] = bcd_out;
      end
      chk("tbl_lit_mask", 32'(lit), 32'(tbl[r].lit));
      chk("tbl_lit_cycles", 32'(litcnt), 32'(DIV * $countones(tbl[r].lit)));
      chk("tbl_fd_count", 32'(fd_cnt), 32'h1);
      chk("tbl_fd_cycle", 32'(fd_cyc), 32'(FRAME));
      chk("tbl_bcd_digits", 32'(seen_bcd), 32'(tbl[r].val));
      step(1'b0, 1'b0, 16'h0, tbl[r].blz);
    end

    // ---------- mid-frame load held until frame end; second load dropped ----------
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h5678, 1'b0);
    chk("mid_ready_low", 32'(ready), 32'h0);
    chk("mid_active_kept", 32'(bcd_out), 32'h3);
    step(1'b1, 1'b1, 16'h9999, 1'b0);
    chk("mid_second_ready", 32'(ready), 32'h0);
    scan_to_fd("mid");
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("mid_commit_ready", 32'(ready), 32'h1);
    chk("mid_commit_bcd", 32'(bcd_out), 32'h8);
    chk("mid_commit_dig", 32'(dig_en), 32'h1);

    // ---------- load in the frame-end cycle waits a whole frame ----------
    scan_to_fd("fe");
    step(1'b1, 1'b1, 16'h4321, 1'b0);
    chk("fe_ready_low", 32'(ready), 32'h0);
    chk("fe_not_committed", 32'(bcd_out), 32'h8);
    scan_to_fd("fe2");
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("fe_commit_ready", 32'(ready), 32'h1);
    chk("fe_commit_bcd", 32'(bcd_out), 32'h1);

    // ---------- en dropped during digit-2 slot ----------
    for (int i = 0; i < 2 * SLOT + 1; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("abort_in_slot2", 32'(dig_en), 32'h4);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("abort_dark", 32'(dig_en), 32'h0);
    fd_any = 0;
    for (int i = 0; i < FRAME + 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      fd_any = fd_any | frame_done;
    end
    chk("abort_no_fd", 32'(fd_any), 32'h0);

    // ---------- reset during pending ----------
    step(1'b0, 1'b1, 16'h12A4, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst_pre_err", 32'(err), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h9999, 1'b0);
    chk("rst_pre_pending", 32'(ready), 32'h0);
    do_reset("rst_mid");
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_first_dig", 32'(dig_en), 32'h1);
    chk("rst_first_bcd", 32'(bcd_out), 32'h0);
    scan_to_fd("rst");
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_pending_dropped", 32'(bcd_out), 32'h0);

    // ---------- randomized traffic against the model ----------
    cur_b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++)
        rv[4 * k +: 4] = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
      if ($urandom_range(31) == 0) cur_b = ~cur_b;
      if ($urandom_range(999) == 0) do_reset("rnd_rst");
      step(($urandom_range(15) != 0), ($urandom_range(7) == 0), rv, cur_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
